// File: rtl/mileage_display.sv
// Mileage display: converts the registered 27-bit mileage to 7 BCD digits with a
// serial shift-add-3 engine and scans them onto an 8-digit seven-segment display.
module mileage_display #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        power_now,
    input  logic [26:0] record,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out,
    output logic        valid
);

    localparam int              CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [26:0]      MAX_MILES = 27'd9_999_999;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [26:0]      r_recQ;
    logic [26:0]      r_bin;
    logic [27:0]      r_bcd;
    logic [27:0]      w_bcdAdj;
    logic [27:0]      r_dispBcd;
    logic [4:0]       r_bitCnt;
    logic             r_valid;
    logic [CNT_W-1:0] r_scanCnt;
    logic [2:0]       r_idx;
    logic [7:0]       w_blank;
    logic [31:0]      w_dispExt;
    logic [3:0]       w_digit;
    logic [6:0]       w_font;

    always_ff @(posedge clk) begin
        if (rst) r_recQ <= '0;
        else     r_recQ <= record;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    w_nextState = SHIFT;
            SHIFT:   if (r_bitCnt == 5'd26) w_nextState = LOAD;
            LOAD:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Add-3 correction on every nibble that would overflow past 9 after doubling
    always_comb begin
        w_bcdAdj = r_bcd;
        for (int k = 0; k < 7; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) w_bcdAdj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin     <= '0;
            r_bcd     <= '0;
            r_bitCnt  <= '0;
            r_dispBcd <= '0;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_bin    <= (r_recQ > MAX_MILES) ? MAX_MILES : r_recQ;
                    r_bcd    <= '0;
                    r_bitCnt <= '0;
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcdAdj[26:0], r_bin, 1'b0};
                    r_bitCnt       <= r_bitCnt + 5'd1;
                end
                LOAD: begin
                    r_dispBcd <= r_bcd;
                    r_valid   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scanCnt <= '0;
            r_idx     <= '0;
        end else if (r_scanCnt == SCAN_LAST) begin
            r_scanCnt <= '0;
            r_idx     <= r_idx + 3'd1;
        end else begin
            r_scanCnt <= r_scanCnt + 1'b1;
        end
    end

    // A digit is a leading zero when it and everything above it is zero
    always_comb begin
        w_blank    = '0;
        w_blank[7] = 1'b1;
        for (int k = 1; k < 7; k++) begin
            w_blank[k] = ((r_dispBcd >> (4*k)) == 28'd0);
        end
    end

    assign w_dispExt = {4'd0, r_dispBcd};
    assign w_digit   = w_dispExt[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_font = 7'b0000000;
        case (w_digit)
            4'd0: w_font = 7'b1111110;
            4'd1: w_font = 7'b0110000;
            4'd2: w_font = 7'b1101101;
            4'd3: w_font = 7'b1111001;
            4'd4: w_font = 7'b0110011;
            4'd5: w_font = 7'b1011011;
            4'd6: w_font = 7'b1011111;
            4'd7: w_font = 7'b1110000;
            4'd8: w_font = 7'b1111111;
            4'd9: w_font = 7'b1111011;
            default: w_font = 7'b0000000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !power_now || !r_valid || w_blank[r_idx]) begin
            seg_en  <= '0;
            seg_out <= '0;
        end else begin
            seg_en  <= 8'd1 << r_idx;
            seg_out <= {w_font, 1'b0};
        end
    end

    assign valid = r_valid;

endmodule

// File: tb/tb_mileage_display.sv
// Scoreboard bench for mileage_display: stimulus schedules expected per-cycle outputs
// into a queue, a negedge monitor pops and compares them against the DUT.
module tb_mileage_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        power_now;
    logic [26:0] record;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;
    logic        valid;

    int cyc       = 0;
    int baseCyc   = 0;
    int passCnt   = 0;
    int totalCnt  = 0;

    typedef struct {
        int         cyc;
        logic [7:0] en;
        logic [7:0] sg;
        logic       v;
        string      name;
    } exp_t;

    exp_t sbq[$];

    mileage_display #(.SCAN_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .power_now(power_now),
        .record   (record),
        .seg_en   (seg_en),
        .seg_out  (seg_out),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] font(int d);
        case (d)
            0: return 8'b11111100;
            1: return 8'b01100000;
            2: return 8'b11011010;
            3: return 8'b11110010;
            4: return 8'b01100110;
            5: return 8'b10110110;
            6: return 8'b10111110;
            7: return 8'b11100000;
            8: return 8'b11111110;
            9: return 8'b11110110;
            default: return 8'b00000000;
        endcase
    endfunction

    // relN = cycles since reset release; outputs after edge relN reflect state after relN-1
    function automatic void model(input int relN, input int value, input bit pwr,
                                  output logic [7:0] en, output logic [7:0] sg, output logic v);
        int idx;
        int tmp;
        int nd;
        int d [7];
        v  = (relN >= 29);
        en = '0;
        sg = '0;
        if (!pwr || relN < 30) return;
        idx = ((relN - 1) / 4) % 8;
        tmp = (value > 9999999) ? 9999999 : value;
        nd  = 1;
        for (int k = 0; k < 7; k++) begin
            d[k] = tmp % 10;
            tmp  = tmp / 10;
            if (d[k] != 0) nd = k + 1;
        end
        if (idx < nd) begin
            en = 8'd1 << idx;
            sg = font(d[idx]);
        end
    endfunction

    task automatic pushRaw(input int c, input logic [7:0] en, input logic [7:0] sg,
                           input logic v, input string name);
        exp_t e;
        e.cyc = c; e.en = en; e.sg = sg; e.v = v; e.name = name;
        sbq.push_back(e);
    endtask

    task automatic checkOutput(input int fromRel, input int toRel, input int value,
                               input bit pwr, input string name);
        logic [7:0] en;
        logic [7:0] sg;
        logic       v;
        for (int r = fromRel; r <= toRel; r++) begin
            model(r, value, pwr, en, sg, v);
            pushRaw(baseCyc + r, en, sg, v, name);
        end
    endtask

    task automatic stepTo(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            totalCnt++;
            if (e.cyc != cyc || seg_en !== e.en || seg_out !== e.sg || valid !== e.v)
                $display("[TB] FAIL %s cyc=%0d got en=%b seg=%b valid=%b want en=%b seg=%b valid=%b",
                         e.name, e.cyc, seg_en, seg_out, valid, e.en, e.sg, e.v);
            else
                passCnt++;
        end
    end

    task automatic applyStimulus();
        rst       = 1'b1;
        power_now = 1'b1;
        record    = 27'd0;
        for (int c = 1; c <= 5; c++) pushRaw(c, 8'd0, 8'd0, 1'b0, "reset");
        stepTo(5);
        rst     = 1'b0;
        baseCyc = cyc;
        checkOutput(1, 70, 0, 1'b1, "first_pass_zero");

        stepTo(baseCyc + 70);
        record = 27'd1_234_567;
        checkOutput(130, 162, 1234567, 1'b1, "digits_1234567");

        stepTo(baseCyc + 162);
        record = 27'd5;
        checkOutput(222, 254, 5, 1'b1, "blank_5");

        stepTo(baseCyc + 254);
        record = 27'h7FF_FFFF;
        checkOutput(314, 346, 9999999, 1'b1, "saturate");

        stepTo(baseCyc + 346);
        record = 27'd42;
        checkOutput(406, 420, 42, 1'b1, "show_42");
        stepTo(baseCyc + 420);
        power_now = 1'b0;
        checkOutput(421, 430, 42, 1'b0, "power_off");
        stepTo(baseCyc + 430);
        power_now = 1'b1;
        checkOutput(431, 470, 42, 1'b1, "power_on");

        // Conversion captured at IDLE relN=494 uses 100; record moves to 200 mid-SHIFT
        stepTo(baseCyc + 470);
        record = 27'd100;
        stepTo(baseCyc + 499);
        record = 27'd200;
        checkOutput(523, 551, 100, 1'b1, "midshift_keeps_100");
        checkOutput(553, 580, 200, 1'b1, "next_pass_200");

        stepTo(baseCyc + 590);
        rst = 1'b1;
        pushRaw(baseCyc + 591, 8'd0, 8'd0, 1'b0, "reset_midshift");
        pushRaw(baseCyc + 592, 8'd0, 8'd0, 1'b0, "reset_midshift");
        stepTo(baseCyc + 592);
        rst     = 1'b0;
        baseCyc = cyc;
        checkOutput(1, 40, 0, 1'b1, "after_reset_zero");
        checkOutput(60, 100, 200, 1'b1, "after_reset_200");
        stepTo(baseCyc + 105);
    endtask

    initial begin
        applyStimulus();
        for (int i = 0; i < 200 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() > 0) begin
            totalCnt++;
            $display("[TB] FAIL drain pending=%0d want 0", sbq.size());
        end
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
